// File: rtl/alarm_sched_pkg.sv
// Shared types and constants for the alarm pattern scheduler.
package alarm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } state_t;

  // Shown on the hex display when no requester owns the output
  localparam logic [3:0] ID_IDLE = 4'hF;

  localparam int PAT_W_DEFAULT = 12;

endpackage

// File: rtl/pattern_shifter.sv
// Parallel-load, shift-left-on-tick pattern register; the MSB is the serial bit.
module pattern_shifter #(
  parameter int PAT_W = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern,
  output logic             msb
);

  logic [PAT_W-1:0] shreg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= pattern;
    end else if (shift) begin
      shreg <= {shreg[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = shreg[PAT_W-1];

endmodule

// File: rtl/alarm_pattern_scheduler.sv
// Arbitrates alarm requesters and plays the winner's pattern serially, one bit per tick.
// Define ALARM_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module alarm_pattern_scheduler
  import alarm_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PAT_W     = PAT_W_DEFAULT,
  parameter int GAP_TICKS = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*PAT_W-1:0] req_pattern,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     bit_out,
  output logic [NUM_REQ-1:0]       done,
  output logic [3:0]               active_id
);

  localparam int CNT_W = $clog2(PAT_W + 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic [3:0]       next_id;
  logic             found;
  logic [31:0]      req_ext;
  logic [PAT_W-1:0] sel_pattern;
  logic             shift_msb;
  logic             last_bit;

  assign req_ext = 32'(req);

`ifdef ALARM_FIXED_PRIORITY_EN
  always_comb begin
    next_id = '0;
    found   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_ext[5'(i)]) begin
        next_id = 4'(i);
        found   = 1'b1;
      end
    end
  end
`else
  logic [3:0] last_grant;
  logic [4:0] pos;

  // Search starts just after the previous winner so every requester gets a turn
  always_comb begin
    next_id = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = 5'(last_grant) + 5'(k);
      if (pos >= 5'(NUM_REQ)) begin
        pos = pos - 5'(NUM_REQ);
      end
      if (!found && req_ext[pos]) begin
        next_id = pos[3:0];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 4'(NUM_REQ - 1);
    end else if (state == IDLE && found) begin
      last_grant <= next_id;
    end
  end
`endif

  always_comb begin
    sel_pattern = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (active_id == 4'(i)) begin
        sel_pattern = req_pattern[i*PAT_W +: PAT_W];
      end
    end
  end

  assign last_bit = (state == PLAY) && tick && (bit_cnt == CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      active_id <= ID_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= LOAD;
            busy      <= 1'b1;
            grant     <= NUM_REQ'(1) << next_id;
            active_id <= next_id;
          end
        end
        LOAD: begin
          state   <= PLAY;
          bit_cnt <= CNT_W'(PAT_W);
        end
        PLAY: begin
          if (tick) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
            if (last_bit) begin
              grant <= '0;
              if (GAP_TICKS == 0) begin
                state     <= IDLE;
                busy      <= 1'b0;
                active_id <= ID_IDLE;
              end else begin
                state   <= GAP;
                gap_cnt <= 4'(GAP_TICKS);
              end
            end
          end
        end
        GAP: begin
          if (tick) begin
            gap_cnt <= gap_cnt - 4'd1;
            if (gap_cnt == 4'd1) begin
              state     <= IDLE;
              busy      <= 1'b0;
              active_id <= ID_IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  pattern_shifter #(
    .PAT_W(PAT_W)
  ) u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (state == LOAD),
    .shift   ((state == PLAY) && tick),
    .pattern (sel_pattern),
    .msb     (shift_msb)
  );

  assign bit_out = (state == PLAY) && shift_msb;
  assign done    = last_bit ? grant : '0;

endmodule

// File: doc/alarm_pattern_scheduler.md
ALARM_PATTERN_SCHEDULER -- requirements
Module: alarm_pattern_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..15.
REQ-002 Parameter PAT_W, default 12: pattern length in bits.
REQ-003 Parameter GAP_TICKS, default 2: silent ticks between patterns, range 0..15.
REQ-004 Port clock  in  1: single clock; all state on posedge.
REQ-005 Port reset_n  in  1: asynchronous, active-low reset.
REQ-006 Port tick  in  1: one-clock enable pulse from a rate divider; sets bit period.
REQ-007 Port req  in  NUM_REQ: level request per requester.
REQ-008 Port req_pattern  in  NUM_REQ*PAT_W: pattern of requester i at [i*PAT_W +: PAT_W]; sent MSB first.
REQ-009 Port grant  out  NUM_REQ: one-hot winner, asserted during LOAD and PLAY.
REQ-010 Port busy  out  1: high whenever state is not IDLE.
REQ-011 Port bit_out  out  1: serial pattern bit.
REQ-012 Port done  out  NUM_REQ: one-clock pulse on the winner's bit when its pattern completes.
REQ-013 Port active_id  out  4: binary winner index in LOAD/PLAY/GAP; 4'hF in IDLE, for the hex display.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, PLAY and GAP.
REQ-015 In IDLE with any req bit high, the FSM SHALL arbitrate that cycle and enter LOAD on the next edge; tick SHALL be ignored in IDLE and LOAD.
REQ-016 Round-robin: search SHALL start at last_grant+1 mod NUM_REQ; last_grant SHALL update on entry to LOAD; reset value NUM_REQ-1, so req[0] wins first.
REQ-017 LOAD SHALL last exactly one clock: capture the winner's slice into the shifter, set bit counter to PAT_W, then enter PLAY.
REQ-018 PLAY: bit_out SHALL equal the shifter MSB; each tick SHALL shift left 1 with zero fill and decrement the counter; each bit SHALL be held exactly one tick period.
REQ-019 On the tick that decrements the counter from 1 to 0, done[winner] SHALL pulse for that one clock; the FSM SHALL enter GAP, or IDLE if GAP_TICKS=0.
REQ-020 GAP: bit_out SHALL be 0; each tick SHALL decrement the gap counter, loaded with GAP_TICKS; at 0 the FSM SHALL enter IDLE.
REQ-021 Playback SHALL be non-preemptive: deasserting req or changing req_pattern after LOAD SHALL NOT alter output, and done SHALL still pulse.
REQ-022 Requests arriving in LOAD/PLAY/GAP SHALL wait until IDLE.
REQ-023 The bit counter width SHALL be $clog2(PAT_W+1); the gap counter SHALL be 4 bits.
REQ-024 bit_out SHALL be 0 in IDLE and GAP.

Reset
REQ-025 reset_n low SHALL immediately clear to: state IDLE, grant 0, busy 0, bit_out 0, done 0, active_id 4'hF, counters 0, last_grant NUM_REQ-1. This SHALL hold even mid-PLAY, and no done pulse SHALL be emitted.
REQ-026 After reset_n rises, the first arbitration SHALL occur on the first edge at which req is nonzero.

Configuration
REQ-027 ALARM_FIXED_PRIORITY_EN defined: arbitration SHALL be fixed priority, with lowest index winning, and last_grant unused. Undefined: round-robin per REQ-016.

Structure
REQ-028 Package alarm_sched_pkg SHALL hold the state typedef (IDLE, LOAD, PLAY, GAP) and the constants ID_IDLE=4'hF and default PAT_W=12.
REQ-029 Sub-module pattern_shifter SHALL implement PAT_W load/shift-on-tick with MSB output; arbitration and FSM stay in the top.

Verification
REQ-030 req=4'b0001, pattern0=12'b1010_0000_0001, tick every 4 clocks -> bit_out 1,0,1,0,0,0,0,0,0,0,0,1 (4 clocks each); done=4'b0001 one clock at tick 12; active_id 0 then 4'hF after 2 gap ticks.
REQ-031 req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001; with ALARM_FIXED_PRIORITY_EN -> 0001 every time.
REQ-032 req[2] dropped after 3 bits -> all 12 bits still played, then done[2] pulses.
REQ-033 reset_n low at bit 5 of PLAY -> bit_out, grant and busy go 0 asynchronously with no done pulse; afterwards req=4'b0110 -> grant 0010.
REQ-034 Back-to-back req[0], req[1] -> bit_out 0 for exactly 2 ticks between patterns; req[3] raised during GAP is served only after IDLE.
REQ-035 pattern=12'h000 -> 12 ticks of bit_out 0, then done pulses normally.
